// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: validates, issues one data-bus access per
// instruction with req/ack handshake, stalls upstream, and extends load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_valid,
    input  logic        lsu_is_load,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_fault,
    output logic [1:0]  lsu_fault_code,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             fault_q, fault_d;
    logic [1:0]       fcode_q, fcode_d;
    logic             stall;

    logic             req_legal;
    logic             req_aligned;
    logic [31:0]      store_data;
    logic [3:0]       store_be;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_data;

    // funct3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word
    always_comb begin
        if (lsu_is_load) begin
            req_legal = (lsu_funct3 == 3'b000) || (lsu_funct3 == 3'b001) ||
                        (lsu_funct3 == 3'b010) || (lsu_funct3 == 3'b100) ||
                        (lsu_funct3 == 3'b101);
        end else begin
            req_legal = (lsu_funct3 == 3'b000) || (lsu_funct3 == 3'b001) ||
                        (lsu_funct3 == 3'b010);
        end
        case (lsu_funct3[1:0])
            2'b00:   req_aligned = 1'b1;
            2'b01:   req_aligned = (lsu_addr[0] == 1'b0);
            default: req_aligned = (lsu_addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        case (lsu_funct3[1:0])
            2'b00: begin
                store_data = {4{lsu_wdata[7:0]}};
                store_be   = 4'b0001 << lsu_addr[1:0];
            end
            2'b01: begin
                store_data = {2{lsu_wdata[15:0]}};
                store_be   = 4'b0011 << lsu_addr[1:0];
            end
            default: begin
                store_data = lsu_wdata;
                store_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dbus_rdata[7:0];
            2'd1:    ld_byte = dbus_rdata[15:8];
            2'd2:    ld_byte = dbus_rdata[23:16];
            default: ld_byte = dbus_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'b0, ld_byte};
            3'b101:  load_data = {16'b0, ld_half};
            default: load_data = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        fcode_d = 2'b00;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_valid) begin
                    if (!req_legal) begin
                        fault_d = 1'b1;
                        fcode_d = FC_ILLEGAL;
                    end else if (!req_aligned) begin
                        fault_d = 1'b1;
                        fcode_d = FC_MISALIGN;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = !lsu_is_load;
                        addr_d  = {lsu_addr[31:2], 2'b00};
                        off_d   = lsu_addr[1:0];
                        f3_d    = lsu_funct3;
                        wdata_d = lsu_is_load ? '0 : store_data;
                        be_d    = lsu_is_load ? 4'b1111 : store_be;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                // An ack in the final allowed cycle still completes the access.
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = load_data;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    fcode_d = FC_TIMEOUT;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            fcode_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            fcode_q <= fcode_d;
        end
    end

    assign lsu_stall      = stall & ~rst;
    assign lsu_done       = (state_q == S_DONE);
    assign lsu_rdata      = rdata_q;
    assign lsu_fault      = fault_q;
    assign lsu_fault_code = fcode_q;
    assign dbus_req       = req_q;
    assign dbus_we        = we_q;
    assign dbus_addr      = addr_q;
    assign dbus_wdata     = wdata_q;
    assign dbus_be        = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against an arithmetic model of the access rules.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_is_load = 1'b0;
    logic [2:0]  lsu_funct3 = '0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_fault;
    logic [1:0]  lsu_fault_code;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rdata_model = '0;

    load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid(lsu_req_valid), .lsu_is_load(lsu_is_load),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_fault(lsu_fault), .lsu_fault_code(lsu_fault_code),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        return f3 <= 2;
    endfunction

    function automatic int unsigned nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] m;
        if (ld) return 4'hF;
        m = 8'(((1 << nbytes(f3)) - 1) << (a % 4));
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (nbytes(f3))
            1:       return {24'b0, w[7:0]} * 32'h01010101;
            2:       return {16'b0, w[15:0]} * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        longint unsigned n = nbytes(f3);
        longint unsigned v = rd;
        longint unsigned span;
        if (n == 4) return rd;
        v = v >> (8 * (a % 4));
        span = 64'd1 << (8 * n);
        v = v % span;
        if (f3 < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // One complete instruction: k is the BUSY cycle (1-based) in which ack arrives.
    task automatic run_access(input string name, input bit ld, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int unsigned k, input logic [31:0] rd);
        bit ok = legal(ld, f3) && aligned(f3, a);
        logic [1:0] code;
        lsu_req_valid = 1'b1; lsu_is_load = ld; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        #1;
        checks++;
        if (lsu_stall !== ok)
            $display("FAIL %s accept_stall: got %b want %b", name, lsu_stall, ok);
        if (lsu_stall !== ok) errors++;
        tick();
        lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_funct3 = 3'($urandom);
        if (!ok) begin
            code = legal(ld, f3) ? 2'b01 : 2'b10;
            checks++;
            if (lsu_fault !== 1'b1 || lsu_fault_code !== code) begin
                $display("FAIL %s fault: got %b/%b want 1/%b", name, lsu_fault, lsu_fault_code, code);
                errors++;
            end
            checks++;
            if (dbus_req !== 1'b0 || lsu_stall !== 1'b0 || lsu_done !== 1'b0) begin
                $display("FAIL %s fault_side: req=%b stall=%b done=%b want 0/0/0", name, dbus_req, lsu_stall, lsu_done);
                errors++;
            end
            tick();
            checks++;
            if (lsu_fault !== 1'b0 || dbus_req !== 1'b0 || lsu_rdata !== rdata_model) begin
                $display("FAIL %s fault_after: fault=%b req=%b rdata=%h want 0/0/%h", name, lsu_fault, dbus_req, lsu_rdata, rdata_model);
                errors++;
            end
            return;
        end
        for (int b = 1; b <= int'(k); b++) begin
            checks++;
            if (dbus_req !== 1'b1 || dbus_we !== !ld || dbus_addr !== {a[31:2], 2'b00} ||
                dbus_be !== exp_be(ld, f3, a) || lsu_stall !== 1'b1 || lsu_done !== 1'b0) begin
                $display("FAIL %s busy%0d: req=%b we=%b addr=%h be=%b stall=%b done=%b want 1/%b/%h/%b/1/0",
                         name, b, dbus_req, dbus_we, dbus_addr, dbus_be, lsu_stall, lsu_done,
                         !ld, {a[31:2], 2'b00}, exp_be(ld, f3, a));
                errors++;
            end
            if (!ld) begin
                checks++;
                if (dbus_wdata !== exp_wdata(f3, wd)) begin
                    $display("FAIL %s wdata: got %h want %h", name, dbus_wdata, exp_wdata(f3, wd));
                    errors++;
                end
            end
            if (b == int'(k)) begin dbus_ack = 1'b1; dbus_rdata = rd; end
            else begin dbus_ack = 1'b0; dbus_rdata = $urandom; end
            tick();
        end
        dbus_ack = 1'b0; dbus_rdata = $urandom;
        if (ld) rdata_model = exp_load(f3, a, rd);
        checks++;
        if (lsu_done !== 1'b1 || lsu_stall !== 1'b0 || dbus_req !== 1'b0 || lsu_fault !== 1'b0) begin
            $display("FAIL %s done: done=%b stall=%b req=%b fault=%b want 1/0/0/0", name, lsu_done, lsu_stall, dbus_req, lsu_fault);
            errors++;
        end
        checks++;
        if (lsu_rdata !== rdata_model) begin
            $display("FAIL %s rdata: got %h want %h", name, lsu_rdata, rdata_model);
            errors++;
        end
        // A request presented while DONE belongs to the retiring instruction.
        lsu_req_valid = 1'b1; lsu_is_load = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h40;
        #1;
        checks++;
        if (lsu_stall !== 1'b0) begin
            $display("FAIL %s done_stall: got %b want 0", name, lsu_stall);
            errors++;
        end
        tick();
        lsu_req_valid = 1'b0;
        checks++;
        if (lsu_done !== 1'b0 || dbus_req !== 1'b0 || lsu_fault !== 1'b0) begin
            $display("FAIL %s after_done: done=%b req=%b fault=%b want 0/0/0", name, lsu_done, dbus_req, lsu_fault);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (lsu_stall !== 0 || lsu_done !== 0 || lsu_rdata !== 0 || lsu_fault !== 0 ||
            lsu_fault_code !== 0 || dbus_req !== 0 || dbus_we !== 0 || dbus_addr !== 0 ||
            dbus_wdata !== 0 || dbus_be !== 0) begin
            $display("FAIL reset_outputs: stall=%b done=%b rdata=%h fault=%b code=%b req=%b we=%b addr=%h wdata=%h be=%b want all 0",
                     lsu_stall, lsu_done, lsu_rdata, lsu_fault, lsu_fault_code, dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be);
            errors++;
        end
        rst = 1'b0;
        rdata_model = '0;
        tick();
    endtask

    task automatic test_loads();
        run_access("lw_0x100", 1, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
        checks++;
        if (lsu_rdata !== 32'hDEADBEEF) begin
            $display("FAIL lw_const: got %h want deadbeef", lsu_rdata); errors++;
        end
        run_access("lb_0x103", 1, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
        checks++;
        if (lsu_rdata !== 32'hFFFFFF80) begin
            $display("FAIL lb_const: got %h want ffffff80", lsu_rdata); errors++;
        end
        run_access("lbu_0x103", 1, 3'b100, 32'h103, 32'h0, 3, 32'h80112233);
        checks++;
        if (lsu_rdata !== 32'h00000080) begin
            $display("FAIL lbu_const: got %h want 00000080", lsu_rdata); errors++;
        end
        run_access("lhu_0x102", 1, 3'b101, 32'h102, 32'h0, 1, 32'h80112233);
        checks++;
        if (lsu_rdata !== 32'h00008011) begin
            $display("FAIL lhu_const: got %h want 00008011", lsu_rdata); errors++;
        end
        run_access("lh_0x102", 1, 3'b001, 32'h102, 32'h0, 2, 32'h80112233);
        checks++;
        if (lsu_rdata !== 32'hFFFF8011) begin
            $display("FAIL lh_const: got %h want ffff8011", lsu_rdata); errors++;
        end
    endtask

    task automatic test_store();
        run_access("sh_0x202", 0, 3'b001, 32'h202, 32'h0000ABCD, 2, 32'h12345678);
        checks++;
        if (lsu_rdata !== 32'hFFFF8011) begin
            $display("FAIL sh_rdata_hold: got %h want ffff8011", lsu_rdata); errors++;
        end
        run_access("sb_0x201", 0, 3'b000, 32'h201, 32'h000000A5, 1, 32'h0);
    endtask

    task automatic test_faults();
        run_access("lw_misaligned", 1, 3'b010, 32'h101, 32'h0, 1, 32'h0);
        run_access("f3_011_illegal", 1, 3'b011, 32'h101, 32'h0, 1, 32'h0);
        run_access("sh_misaligned", 0, 3'b001, 32'h203, 32'h1234, 1, 32'h0);
        run_access("store_f3_100", 0, 3'b100, 32'h203, 32'h1234, 1, 32'h0);
    endtask

    task automatic test_timeout();
        lsu_req_valid = 1'b1; lsu_is_load = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h300;
        tick();
        lsu_req_valid = 1'b0;
        for (int b = 1; b <= int'(TO); b++) begin
            checks++;
            if (dbus_req !== 1'b1 || lsu_stall !== 1'b1) begin
                $display("FAIL timeout_busy%0d: req=%b stall=%b want 1/1", b, dbus_req, lsu_stall);
                errors++;
            end
            tick();
        end
        checks++;
        if (dbus_req !== 1'b0 || lsu_fault !== 1'b1 || lsu_fault_code !== 2'b11 ||
            lsu_done !== 1'b0 || lsu_stall !== 1'b0) begin
            $display("FAIL timeout_abort: req=%b fault=%b code=%b done=%b stall=%b want 0/1/11/0/0",
                     dbus_req, lsu_fault, lsu_fault_code, lsu_done, lsu_stall);
            errors++;
        end
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFEF00D;
        tick();
        dbus_ack = 1'b0;
        checks++;
        if (lsu_done !== 1'b0 || lsu_fault !== 1'b0 || dbus_req !== 1'b0 || lsu_rdata !== rdata_model) begin
            $display("FAIL late_ack: done=%b fault=%b req=%b rdata=%h want 0/0/0/%h",
                     lsu_done, lsu_fault, dbus_req, lsu_rdata, rdata_model);
            errors++;
        end
        run_access("ack_at_limit", 1, 3'b010, 32'h304, 32'h0, TO, 32'h0BADF00D);
    endtask

    task automatic test_reset_mid_busy();
        lsu_req_valid = 1'b1; lsu_is_load = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h400; lsu_wdata = 32'h55AA55AA;
        tick();
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdata_model = '0;
        checks++;
        if (dbus_req !== 1'b0 || lsu_stall !== 1'b0 || lsu_done !== 1'b0 || lsu_fault !== 1'b0) begin
            $display("FAIL rst_mid_busy: req=%b stall=%b done=%b fault=%b want 0/0/0/0", dbus_req, lsu_stall, lsu_done, lsu_fault);
            errors++;
        end
        tick();
        checks++;
        if (lsu_done !== 1'b0 || lsu_fault !== 1'b0 || dbus_req !== 1'b0) begin
            $display("FAIL rst_mid_busy_after: done=%b fault=%b req=%b want 0/0/0", lsu_done, lsu_fault, dbus_req);
            errors++;
        end
        run_access("lw_after_rst", 1, 3'b010, 32'h404, 32'h0, 2, 32'h13579BDF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit          ld = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            run_access($sformatf("rand%0d", i), ld, f3, a, $urandom, $urandom_range(1, TO), $urandom);
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store();
        test_faults();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
